// File: rtl/punc_ctrl_defs.sv
// Shared encodings for the PUnC control unit and datapath: opcodes, FSM states
// and every mux select value that crosses the control/datapath boundary.
package punc_ctrl_defs;

  // Reset value of PC; the datapath applies it when pc_clr is asserted.
  localparam logic [15:0] PC_START = 16'h0000;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] MEM_ADDR_PC    = 2'b00;
  localparam logic [1:0] MEM_ADDR_ALU   = 2'b01;
  localparam logic [1:0] MEM_ADDR_STORE = 2'b10;

  localparam logic [1:0] RF_W_PC  = 2'b00;
  localparam logic [1:0] RF_W_MEM = 2'b01;
  localparam logic [1:0] RF_W_ALU = 2'b10;

  localparam logic PC_DATA_ADDER = 1'b0;
  localparam logic PC_DATA_BASE  = 1'b1;

  localparam logic PC_ADD_OFF11 = 1'b0;
  localparam logic PC_ADD_OFF9  = 1'b1;

  localparam logic [1:0] SEXT_IMM5  = 2'b00;
  localparam logic [1:0] SEXT_OFF6  = 2'b01;
  localparam logic [1:0] SEXT_OFF9  = 2'b10;
  localparam logic [1:0] SEXT_OFF11 = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_AND    = 2'b01;
  localparam logic [1:0] ALU_NOT    = 2'b10;
  localparam logic [1:0] ALU_PASS_A = 2'b11;

endpackage

// File: rtl/punc_branch_eval.sv
// BR condition check: takes the branch when any requested flag in ir[11:9]
// (n, z, p order) is currently set.
module punc_branch_eval (
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       p,
  output logic       take
);

  assign take = (cond[2] & n) | (cond[1] & z) | (cond[0] & p);

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: fetch/decode/execute sequencing and all datapath strobes.
// Build option PUNC_ILLEGAL_HALT_EN: opcodes 1000/1101 halt and raise illegal_op.
module punc_control
  import punc_ctrl_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        pc_data_sel,
  output logic        pc_add_sel,
  output logic        ir_ld,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic        store_ld,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  sext_sel,
  output logic [1:0]  alu_sel,
  output logic        nzp_ld,
  output logic        nzp_sel,
  output logic        halted,
  output logic        illegal_op,
  output logic [2:0]  state_dbg
);

  state_e     state, state_next;
  logic [3:0] op;
  logic       br_take;
  logic       unused_ir_bits;

  assign op             = ir[15:12];
  assign state_dbg      = state;
  assign unused_ir_bits = ^ir[4:3];

  punc_branch_eval u_branch_eval (
    .cond (ir[11:9]),
    .n    (n),
    .z    (z),
    .p    (p),
    .take (br_take)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_next;
  end

`ifdef PUNC_ILLEGAL_HALT_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                   illegal_q <= 1'b0;
    else if (state == S_EXEC && (op == OP_RTI || op == OP_RES)) illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    pc_clr       = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    pc_data_sel  = PC_DATA_ADDER;
    pc_add_sel   = PC_ADD_OFF11;
    ir_ld        = 1'b0;
    mem_addr_sel = MEM_ADDR_PC;
    mem_w_en     = 1'b0;
    store_ld     = 1'b0;
    rf_r_addr_0  = 3'd0;
    rf_r_addr_1  = 3'd0;
    rf_w_addr    = 3'd0;
    rf_w_en      = 1'b0;
    rf_w_sel     = RF_W_PC;
    a_sel        = 1'b0;
    b_sel        = 1'b0;
    sext_sel     = SEXT_IMM5;
    alu_sel      = ALU_ADD;
    nzp_ld       = 1'b0;
    nzp_sel      = 1'b0;
    halted       = 1'b0;

    case (state)
      S_INIT: begin
        // Held quiet while reset is still asserted; clears PC on the exit cycle.
        pc_clr     = rst;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_addr_sel = MEM_ADDR_PC;
        ir_ld        = 1'b1;
        pc_inc       = 1'b1;
        state_next   = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        rf_w_addr  = ir[11:9];
        state_next = S_FETCH;
        // Memory address generation: base+off6 or PC+off9 through the ALU adder.
        if (op == OP_LDR || op == OP_STR) begin
          a_sel       = 1'b1;
          rf_r_addr_0 = ir[8:6];
          b_sel       = 1'b1;
          sext_sel    = SEXT_OFF6;
        end else if (op == OP_LD || op == OP_ST || op == OP_LDI ||
                     op == OP_STI || op == OP_LEA) begin
          b_sel    = 1'b1;
          sext_sel = SEXT_OFF9;
        end
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            a_sel       = 1'b1;
            rf_r_addr_0 = ir[8:6];
            if (op == OP_NOT)    alu_sel = ALU_NOT;
            else if (op == OP_AND) alu_sel = ALU_AND;
            else                   alu_sel = ALU_ADD;
            if (op != OP_NOT) begin
              if (ir[5]) begin
                b_sel    = 1'b1;
                sext_sel = SEXT_IMM5;
              end else begin
                rf_r_addr_1 = ir[2:0];
              end
            end
            rf_w_en  = 1'b1;
            rf_w_sel = RF_W_ALU;
            nzp_ld   = 1'b1;
          end
          OP_BR: begin
            if (br_take) begin
              pc_ld       = 1'b1;
              pc_data_sel = PC_DATA_ADDER;
              pc_add_sel  = PC_ADD_OFF9;
            end
          end
          OP_JMP: begin
            a_sel       = 1'b1;
            rf_r_addr_0 = ir[8:6];
            alu_sel     = ALU_PASS_A;
            pc_ld       = 1'b1;
            pc_data_sel = PC_DATA_BASE;
          end
          OP_JSR: begin
            // R7 captures the already-incremented PC while PC takes the target.
            rf_w_addr = 3'd7;
            rf_w_sel  = RF_W_PC;
            rf_w_en   = 1'b1;
            pc_ld     = 1'b1;
            if (ir[11]) begin
              pc_data_sel = PC_DATA_ADDER;
              pc_add_sel  = PC_ADD_OFF11;
            end else begin
              rf_r_addr_0 = ir[8:6];
              pc_data_sel = PC_DATA_BASE;
            end
          end
          OP_LD, OP_LDR: begin
            mem_addr_sel = MEM_ADDR_ALU;
            rf_w_sel     = RF_W_MEM;
            rf_w_en      = 1'b1;
            nzp_ld       = 1'b1;
            nzp_sel      = 1'b1;
          end
          OP_LEA: begin
            rf_w_sel = RF_W_ALU;
            rf_w_en  = 1'b1;
          end
          OP_ST, OP_STR: begin
            mem_addr_sel = MEM_ADDR_ALU;
            rf_r_addr_1  = ir[11:9];
            mem_w_en     = 1'b1;
          end
          OP_LDI, OP_STI: begin
            mem_addr_sel = MEM_ADDR_ALU;
            store_ld     = 1'b1;
            state_next   = S_EXEC2;
          end
          OP_TRAP: state_next = S_HALT;
`ifdef PUNC_ILLEGAL_HALT_EN
          OP_RTI, OP_RES: state_next = S_HALT;
`endif
          default: ;
        endcase
      end
      S_EXEC2: begin
        mem_addr_sel = MEM_ADDR_STORE;
        rf_w_addr    = ir[11:9];
        state_next   = S_FETCH;
        if (op == OP_LDI) begin
          rf_w_sel = RF_W_MEM;
          rf_w_en  = 1'b1;
          nzp_ld   = 1'b1;
          nzp_sel  = 1'b1;
        end else begin
          rf_r_addr_1 = ir[11:9];
          mem_w_en    = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_INIT;
    endcase
  end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control FSM for the PUnC LC3 processor; sits directly upstream of the PUnC datapath.
- Consumes the datapath's IR and N/Z/P flags; produces every select, load and write-enable the datapath needs.
- Runs a multi-cycle fetch/decode/execute sequence, one instruction at a time, until HALT.

Parameters:
- PC_START, 16'h0000, value loaded into PC via pc_clr at reset exit (informational; the datapath applies it).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ir  in  16  current instruction register
- n, z, p  in  1 each  condition flags from datapath
- pc_clr, pc_inc, pc_ld  out  1  PC control
- pc_data_sel  out  1  0=PC adder, 1=base register
- pc_add_sel  out  1  0=PCoffset11, 1=PCoffset9
- ir_ld  out  1  load IR from memory read data
- mem_addr_sel  out  2  00=PC, 01=ALU result, 10=store reg
- mem_w_en  out  1  memory write
- store_ld  out  1  capture memory read data into store reg (LDI/STI)
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  out  3 each  register file addresses
- rf_w_en  out  1  register file write
- rf_w_sel  out  2  00=PC, 01=MEM, 10=ALU
- a_sel  out  1  0=PC, 1=RF port 0
- b_sel  out  1  0=RF port 1, 1=sext
- sext_sel  out  2  00=imm5, 01=off6, 10=off9, 11=off11
- alu_sel  out  2  00=ADD, 01=AND, 10=NOT, 11=PASS_A
- nzp_ld  out  1  load N/Z/P
- nzp_sel  out  1  0=ALU result, 1=MEM data
- halted  out  1  in HALT state
- illegal_op  out  1  see Optional Feature

Behaviour:
- States:
  - INIT: pc_clr=1 for one cycle after rst releases, then FETCH.
  - FETCH: mem_addr_sel=00, ir_ld=1, pc_inc=1, then DECODE.
  - DECODE: all strobes 0, then EXEC.
  - EXEC: as below.
  - EXEC2: LDI/STI only.
  - HALT: terminal.
- Reset (rst=0, asynchronous): state=INIT; all outputs 0; halted=0. Reset mid-instruction aborts it with no write.
- All outputs are Moore/decoded from state+ir. No strobe is asserted outside the listed states.
- EXEC per ir[15:12]. Unless stated otherwise, rf_w_addr=ir[11:9] and next state is FETCH.
  - ADD 0001 / AND 0101: a_sel=1, r0=ir[8:6]. If ir[5]=1: b_sel=1, sext=imm5; else r1=ir[2:0]. alu_sel=ADD/AND; rf_w_en=1, rf_w_sel=ALU; nzp_ld=1, nzp_sel=0.
  - NOT 1001: r0=ir[8:6], alu=NOT; write and nzp as ADD.
  - BR 0000: if (ir[11]&n)|(ir[10]&z)|(ir[9]&p): pc_ld=1, pc_data_sel=0, pc_add_sel=1. ir[11:9]=000 never branches.
  - JMP 1100: r0=ir[8:6], alu=PASS_A, pc_ld=1, pc_data_sel=1.
  - JSR 0100: rf_w_addr=7, rf_w_sel=PC, rf_w_en=1, pc_ld=1.
    - ir[11]=1: pc_data_sel=0, pc_add_sel=0.
    - else: r0=ir[8:6], pc_data_sel=1.
    - R7 receives the pre-jump (already incremented) PC in the same cycle.
  - LD 0010 / LDR 0110: ALU address = PC+off9 (a_sel=0, sext=off9) or R[ir[8:6]]+off6. mem_addr_sel=01, rf_w_sel=MEM, rf_w_en=1, nzp_ld=1, nzp_sel=1.
  - LEA 1110: PC+off9 via ALU, rf_w_sel=ALU, rf_w_en=1, no nzp_ld.
  - ST 0011 / STR 0111: address as LD/LDR; r1=ir[11:9]; mem_w_en=1.
  - LDI 1010 / STI 1011: EXEC addresses PC+off9, store_ld=1, then EXEC2.
  - EXEC2: mem_addr_sel=10. LDI: write RF from MEM, nzp_ld=1, nzp_sel=1. STI: r1=ir[11:9], mem_w_en=1.
  - TRAP 1111: HALT.
  - 1000, 1101: see Optional Feature.
- HALT: all strobes 0, halted=1, held until rst.
- CPI: ALU/BR/JMP/JSR/LD/LEA/ST = 3 cycles; LDI/STI = 4.

Optional Feature:
- Macro: PUNC_ILLEGAL_HALT_EN.
- Defined: opcodes 1000 and 1101 go to HALT and set illegal_op=1 (sticky until rst).
- Undefined: those opcodes execute as NOP (EXEC asserts nothing, returns to FETCH); illegal_op tied 0.

Decomposition:
- Package/defines file punc_ctrl_defs: opcode constants, state encodings, and all select encodings (mem_addr, rf_w, pc_data, pc_add, sext, alu).
- The datapath includes the same file.
- One combinational sub-module: punc_branch_eval (ir[11:9], n, z, p -> take).

Test Plan:
- Release rst -> one cycle pc_clr=1, then FETCH with ir_ld=1, pc_inc=1, mem_addr_sel=00.
- ir=16'h1261 (ADD R1,R1,#1) -> EXEC: a_sel=1, b_sel=1, sext_sel=00, alu_sel=00, rf_w_addr=1, rf_w_en=1, nzp_ld=1; back to FETCH 3 cycles after FETCH entry.
- ir=16'h0402 (BRz +2):
  - z=1 -> pc_ld=1, pc_add_sel=1, pc_data_sel=0.
  - z=0,n=1 -> pc_ld=0.
- ir=16'hA405 (LDI R2) -> EXEC store_ld=1, mem_addr_sel=01; EXEC2 mem_addr_sel=10, rf_w_sel=01, rf_w_addr=2, nzp_sel=1; 4-cycle instruction.
- ir=16'hF025 (TRAP) -> HALT, halted=1, no further ir_ld. Pulse rst low mid-HALT -> INIT, halted=0.
- ir=16'h8000 -> with PUNC_ILLEGAL_HALT_EN: HALT, illegal_op=1; without: no strobes, next state FETCH.
